// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// opcode/funct constants, ALU encodings, FSM states and the control word.
package mips_ctrl_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_NOP = 6'h00;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation encodings understood by the datapath
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // Sequencer states; FETCH..WB form the four-phase instruction loop
   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_FETCH  = 3'd2,
      ST_DECODE = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WB     = 3'd5,
      ST_STOP   = 3'd6
   } state_t;

   // Decoded control word for one instruction
   typedef struct packed {
      logic [3:0] alu_op;
      logic       selec_mux;   // 0 = rt destination, 1 = rd destination
      logic       selec_mux2;  // 0 = register operand, 1 = immediate
      logic       writes;      // register file written in WB
      logic       halt;        // HALT: stop after retiring
      logic       illegal;     // undecodable word
   } ctrl_t;

   // Build a legal control word from its fields
   function automatic ctrl_t make_ctrl(input logic [3:0] alu,
                                       input logic       rd_dst,
                                       input logic       imm_b,
                                       input logic       wr,
                                       input logic       halt);
      ctrl_t c;
      c.alu_op     = alu;
      c.selec_mux  = rd_dst;
      c.selec_mux2 = imm_b;
      c.writes     = wr;
      c.halt       = halt;
      c.illegal    = 1'b0;
      return c;
   endfunction

   // Control word reported for anything outside the decode table
   localparam ctrl_t CTRL_ILLEGAL = '{alu_op:     ALU_AND,
                                      selec_mux:  1'b0,
                                      selec_mux2: 1'b0,
                                      writes:     1'b0,
                                      halt:       1'b0,
                                      illegal:    1'b1};

endpackage

// File: rtl/mips_ctrl_fsm_decoder.sv
// Purely combinational instruction decoder: instruction register in,
// control word out. Only opcode and funct take part in decoding.
module mips_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output ctrl_t       cw
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_fields;

   assign opcode = ir[31:26];
   assign funct  = ir[5:0];
   // Register numbers, shamt and immediate are datapath business only
   assign unused_fields = ^ir[25:6];

   // Map opcode/funct onto the control word; unknown encodings are illegal
   always_comb begin
      cw = CTRL_ILLEGAL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cw = make_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
               FN_SUB:  cw = make_ctrl(ALU_SUB, 1'b1, 1'b0, 1'b1, 1'b0);
               FN_AND:  cw = make_ctrl(ALU_AND, 1'b1, 1'b0, 1'b1, 1'b0);
               FN_OR:   cw = make_ctrl(ALU_OR,  1'b1, 1'b0, 1'b1, 1'b0);
               FN_SLT:  cw = make_ctrl(ALU_SLT, 1'b1, 1'b0, 1'b1, 1'b0);
               // NOP still advances the PC but writes nothing
               FN_NOP:  cw = make_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0);
               default: cw = CTRL_ILLEGAL;
            endcase
         end
         OP_ADDI: cw = make_ctrl(ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
         OP_ANDI: cw = make_ctrl(ALU_AND, 1'b0, 1'b1, 1'b1, 1'b0);
         OP_ORI:  cw = make_ctrl(ALU_OR,  1'b0, 1'b1, 1'b1, 1'b0);
         OP_SLTI: cw = make_ctrl(ALU_SLT, 1'b0, 1'b1, 1'b1, 1'b0);
         OP_HALT: cw = make_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1);
         default: cw = CTRL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control sequencer for the single-cycle MIPS datapath.
// Each instruction walks FETCH -> DECODE -> EXEC -> WB; every datapath
// control is a register loaded with the value it must hold in the next
// state, so all outputs change only on clock edges (or on reset).
// The current state is exported on 'state' for observation.
module mips_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [31:0]      instr,
   output logic             en,
   output logic             en_rf,
   output logic             rst_rf,
   output logic             selec_mux,
   output logic             selec_mux2,
   output logic [3:0]       alu_op,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output state_t           state
);

   logic [31:0] ir;
   ctrl_t       dec_cw;
   logic        wb_writes;
   logic        wb_halt;

   mips_decoder u_decoder (
      .ir (ir),
      .cw (dec_cw)
   );

   // Sequencer: next state plus the registered controls for that state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_INIT;
         ir         <= '0;
         wb_writes  <= 1'b0;
         wb_halt    <= 1'b0;
         en         <= 1'b0;
         en_rf      <= 1'b0;
         rst_rf     <= 1'b1;
         selec_mux  <= 1'b0;
         selec_mux2 <= 1'b0;
         alu_op     <= ALU_AND;
         busy       <= 1'b0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
         retired    <= '0;
      end else begin
         case (state)
            // Register-file clear is held for exactly this one cycle
            ST_INIT: begin
               rst_rf <= 1'b0;
               state  <= ST_IDLE;
            end

            ST_IDLE: begin
               if (run) begin
                  busy  <= 1'b1;
                  state <= ST_FETCH;
               end
            end

            // The instruction word is only ever sampled here
            ST_FETCH: begin
               ir    <= instr;
               state <= ST_DECODE;
            end

            // Selects and ALU op go live for EXEC and stay through WB
            ST_DECODE: begin
               if (dec_cw.illegal) begin
                  illegal <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_STOP;
               end else begin
                  wb_writes  <= dec_cw.writes;
                  wb_halt    <= dec_cw.halt;
                  alu_op     <= dec_cw.alu_op;
                  selec_mux  <= dec_cw.selec_mux;
                  selec_mux2 <= dec_cw.selec_mux2;
                  state      <= ST_EXEC;
               end
            end

            // PC and register file update together on the WB edge
            ST_EXEC: begin
               en    <= 1'b1;
               en_rf <= wb_writes;
               state <= ST_WB;
            end

            // Retire, clear the controls, and pick the next instruction
            ST_WB: begin
               en         <= 1'b0;
               en_rf      <= 1'b0;
               selec_mux  <= 1'b0;
               selec_mux2 <= 1'b0;
               alu_op     <= ALU_AND;
               retired    <= retired + CNT_W'(1);
               if (wb_halt) begin
                  halted <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_STOP;
               end else if (run) begin
                  state  <= ST_FETCH;
               end else begin
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end
            end

            // Terminal: only reset leaves this state
            ST_STOP: begin
               state <= ST_STOP;
            end

            default: begin
               en     <= 1'b0;
               en_rf  <= 1'b0;
               busy   <= 1'b0;
               state  <= ST_STOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Bench for mips_ctrl_fsm: directed program plus randomized instruction
// streams, checked cycle by cycle against a table-driven reference model.
module tb_mips_ctrl_fsm;
   import mips_ctrl_pkg::*;

   localparam int CW = 4;  // small counter so wrap-around is reached

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic [31:0]   instr;
   logic          en, en_rf, rst_rf, selec_mux, selec_mux2;
   logic [3:0]    alu_op;
   logic          busy, halted, illegal;
   logic [CW-1:0] retired;
   state_t        state;

   int vectors     = 0;
   int miscompares = 0;
   int exp_ret     = 0;
   logic exp_halted  = 1'b0;
   logic exp_illegal = 1'b0;

   // Reference decode table
   localparam logic [5:0] R_FN  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
   localparam logic [3:0] R_ALU [6] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'h0};
   localparam logic       R_WR  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic [5:0] I_OP  [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
   localparam logic [3:0] I_ALU [4] = '{4'h2, 4'h0, 4'h1, 4'h7};

   typedef struct packed {
      logic [3:0] alu;
      logic       sm;
      logic       sm2;
      logic       wr;
      logic       halt;
      logic       bad;
   } exp_t;

   mips_ctrl_fsm #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .instr      (instr),
      .en         (en),
      .en_rf      (en_rf),
      .rst_rf     (rst_rf),
      .selec_mux  (selec_mux),
      .selec_mux2 (selec_mux2),
      .alu_op     (alu_op),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal),
      .retired    (retired),
      .state      (state)
   );

   always #5 clk = ~clk;

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t e;
      e = '{alu: 4'h0, sm: 1'b0, sm2: 1'b0, wr: 1'b0, halt: 1'b0, bad: 1'b1};
      if (w[31:26] == 6'h00) begin
         for (int i = 0; i < 6; i++)
            if (w[5:0] == R_FN[i]) begin
               e.alu = R_ALU[i];
               e.sm  = R_WR[i];   // writing R-types target rd; NOP selects rt
               e.wr  = R_WR[i];
               e.bad = 1'b0;
            end
      end else if (w[31:26] == 6'h3F) begin
         e.halt = 1'b1;
         e.bad  = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (w[31:26] == I_OP[i]) begin
               e.alu = I_ALU[i];
               e.sm2 = 1'b1;
               e.wr  = 1'b1;
               e.bad = 1'b0;
            end
      end
      return e;
   endfunction

   // Rows 0..5 are R-type, 6..9 are I-type; don't-care fields randomized
   function automatic logic [31:0] row_word(input int idx);
      logic [19:0] mid;
      logic [25:0] low;
      mid = 20'($urandom);
      low = 26'($urandom);
      if (idx < 6) return {6'h00, mid, R_FN[idx]};
      return {I_OP[idx-6], low};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic want(input string tag, input logic e_en, input logic e_wr,
                       input logic e_rrf, input logic e_sm, input logic e_sm2,
                       input logic [3:0] e_alu, input logic e_busy, input state_t e_st);
      check({tag, "_ctl"}, {22'd0, en, en_rf, rst_rf, selec_mux, selec_mux2, alu_op, busy},
            {22'd0, e_en, e_wr, e_rrf, e_sm, e_sm2, e_alu, e_busy});
      check({tag, "_state"}, 32'(state), 32'(e_st));
      check({tag, "_flags"}, {30'd0, halted, illegal}, {30'd0, exp_halted, exp_illegal});
      check({tag, "_retired"}, 32'(retired), 32'(exp_ret));
   endtask

   // Async reset mid-cycle, INIT cycle, one IDLE cycle with run=1; ends in FETCH
   task automatic do_reset();
      rst = 1'b0;
      run = 1'b0;
      exp_ret = 0;
      exp_halted = 1'b0;
      exp_illegal = 1'b0;
      #1;
      want("async_reset", 0, 0, 1, 0, 0, 4'h0, 0, ST_INIT);
      tick();
      want("in_reset", 0, 0, 1, 0, 0, 4'h0, 0, ST_INIT);
      rst = 1'b1;
      #2;
      want("init", 0, 0, 1, 0, 0, 4'h0, 0, ST_INIT);
      run = 1'b1;
      tick();
      want("idle", 0, 0, 0, 0, 0, 4'h0, 0, ST_IDLE);
      tick();
   endtask

   // Starts in a FETCH cycle. Ends in FETCH, IDLE or STOP per the model.
   task automatic run_instr(input logic [31:0] w, input logic run_wb, input logic abort);
      exp_t e;
      e = ref_decode(w);
      instr = w;
      run = 1'($urandom_range(0, 1));
      want("fetch", 0, 0, 0, 0, 0, 4'h0, 1, ST_FETCH);
      tick();
      instr = $urandom;   // must be ignored outside FETCH
      run = 1'($urandom_range(0, 1));
      want("decode", 0, 0, 0, 0, 0, 4'h0, 1, ST_DECODE);
      tick();
      if (e.bad) begin
         exp_illegal = 1'b1;
         want("illegal", 0, 0, 0, 0, 0, 4'h0, 0, ST_STOP);
         return;
      end
      want("exec", 0, 0, 0, e.sm, e.sm2, e.alu, 1, ST_EXEC);
      if (abort) return;
      run = run_wb;
      tick();
      want("wb", 1, e.wr, 0, e.sm, e.sm2, e.alu, 1, ST_WB);
      tick();
      exp_ret = (exp_ret + 1) % (1 << CW);
      if (e.halt) begin
         exp_halted = 1'b1;
         want("after_halt", 0, 0, 0, 0, 0, 4'h0, 0, ST_STOP);
      end else if (run_wb) begin
         want("next_fetch", 0, 0, 0, 0, 0, 4'h0, 1, ST_FETCH);
      end else begin
         want("to_idle", 0, 0, 0, 0, 0, 4'h0, 0, ST_IDLE);
      end
   endtask

   // Linger in IDLE with run low, then raise run; ends in FETCH
   task automatic resume();
      int n;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
         instr = $urandom;
         tick();
         want("idle_hold", 0, 0, 0, 0, 0, 4'h0, 0, ST_IDLE);
      end
      run = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b0;
      instr = '0;
      #1;
      do_reset();

      // Small program: addi r1,5 ; addi r2,10 ; add r3,r1,r2
      run_instr(32'h20010005, 1'b1, 1'b0);
      run_instr(32'h2002000A, 1'b1, 1'b0);
      run_instr(32'h00221820, 1'b1, 1'b0);
      check("retired_after_program", 32'(retired), 32'd3);

      // Every decode row once
      for (int i = 0; i < 10; i++) run_instr(row_word(i), 1'b1, 1'b0);

      // Random stream with random run drops (counter wraps along the way)
      for (int n = 0; n < 40; n++) begin
         logic r;
         r = ($urandom_range(0, 3) != 0);
         run_instr(row_word($urandom_range(0, 9)), r, 1'b0);
         if (!r) resume();
      end

      // run dropped during EXEC of an addi, then resumed
      run_instr(row_word(6), 1'b0, 1'b0);
      resume();

      // NOP then HALT; nothing further may happen
      run_instr(32'h00000000, 1'b1, 1'b0);
      run_instr(32'hFC000000, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         want("halt_hold", 0, 0, 0, 0, 0, 4'h0, 0, ST_STOP);
      end

      // Unsupported lw
      do_reset();
      run_instr(32'h8C010000, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         want("illegal_hold", 0, 0, 0, 0, 0, 4'h0, 0, ST_STOP);
      end

      // R-type with an unknown funct
      do_reset();
      run_instr(32'h00221821, 1'b1, 1'b0);

      // Reset during EXEC aborts the instruction
      do_reset();
      run_instr(32'h20010005, 1'b1, 1'b0);
      run_instr(32'h20030007, 1'b1, 1'b1);
      do_reset();
      run_instr(32'h20030007, 1'b1, 1'b0);
      check("retired_after_abort", 32'(retired), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multi-cycle control sequencer placed directly upstream of the single-cycle MIPS datapath `top`. It latches the fetched instruction word, decodes it, and drives the datapath control inputs (`en`, `en_rf`, `rst_rf`, `selec_mux`, `selec_mux2`, `alu_op`) in a fixed four-phase sequence per instruction. It also reports retirement, halt, and illegal-instruction status. This replaces hand-driven controls in benches and is the first step toward the pipelined control path.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `run`  input  1  level; permits leaving IDLE and continuing after each instruction.
- `instr`  input  32  instruction word currently addressed by the datapath PC.
- `en`  output  1  PC enable into datapath.
- `en_rf`  output  1  register-file write enable.
- `rst_rf`  output  1  register-file clear, active-high.
- `selec_mux`  output  1  destination select: 0 = rt, 1 = rd.
- `selec_mux2`  output  1  ALU B operand: 0 = register rD2, 1 = sign-extended immediate.
- `alu_op`  output  4  ALU operation.
- `busy`  output  1  high in FETCH/DECODE/EXEC/WB.
- `halted`  output  1  sticky after HALT is retired.
- `illegal`  output  1  sticky after an undecodable word.
- `retired`  output  CNT_W  count of completed instructions.

## Operation
- States: INIT, IDLE, FETCH, DECODE, EXEC, WB, STOP.
- INIT: occupies the first cycle after reset release and drives `rst_rf=1`. Transitions to IDLE.
- IDLE → FETCH when `run=1`. Otherwise stays in IDLE.
- FETCH: captures `instr` into IR at the end of the cycle, then goes to DECODE.
- DECODE: registers the control word decoded from IR, then goes to EXEC. An illegal word sets `illegal` and goes to STOP instead.
- EXEC: drives `alu_op`, `selec_mux`, `selec_mux2` from the control word. `en` and `en_rf` are 0. Goes to WB.
- WB: same selects as EXEC, plus `en=1`, `en_rf`=writes-flag, and `retired` increments. Exits to FETCH if `run=1`, else IDLE.
- HALT retiring in WB: sets `halted` and goes to STOP instead of FETCH/IDLE.
- STOP: all enables are 0 and state is held until reset.
- Decode table (opcode/funct hex → alu_op, selec_mux, selec_mux2, writes):
  - R-type op 00: funct 20 add → 0010,1,0,1; 22 sub → 0110,1,0,1; 24 and → 0000,1,0,1; 25 or → 0001,1,0,1; 2A slt → 0111,1,0,1.
  - R-type op 00, funct 00 (NOP, incl. 0x00000000) → 0000,0,0,0. The PC still advances.
  - I-type: op 08 addi → 0010,0,1,1; 0C andi → 0000,0,1,1; 0D ori → 0001,0,1,1; 0A slti → 0111,0,1,1.
  - op 3F: HALT, no write, PC still advances.
  - Anything else: illegal.
- `retired` wraps modulo 2^CNT_W. There is no saturation.

## Timing
- Reset values, asserted immediately and asynchronously:
  - `en=0`, `en_rf=0`, `rst_rf=1`, `selec_mux=0`, `selec_mux2=0`, `alu_op=0000`.
  - `busy=0`, `halted=0`, `illegal=0`, `retired=0`, state=INIT.
- `rst_rf` is high during reset and during the INIT cycle, and 0 in every other state.
- CPI is exactly 4 while `run` stays high: FETCH, DECODE, EXEC, WB.
- The first FETCH follows the IDLE cycle in which `run=1` is sampled.
- `en` and `en_rf` are high for exactly one cycle per instruction (WB). The PC and RF therefore update on the same edge.
- Selects and `alu_op` are stable from EXEC through the end of WB. Outside EXEC/WB they return to 0/0000.
- `instr` is sampled only at the end of FETCH. Changes in any other cycle are ignored.
- `run` is sampled only in IDLE and WB. Dropping it mid-instruction completes that instruction.
- Reset asserted mid-instruction aborts it. No `en`/`en_rf` pulse is emitted after the reset edge.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode/funct constants
  - ALU op encodings (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111)
  - the state enum
  - a packed control-word typedef {alu_op, selec_mux, selec_mux2, writes, halt, illegal}
- Sub-module `mips_decoder` is purely combinational: IR → control word. It is instantiated once by the FSM.

## Test plan
- Reset, then `run=1` and hold `instr` per PC: 0x20010005, 0x2002000A, 0x00221820.
  - Connected to `top`, the ALU result in each WB is 5, 10, 15.
  - `retired=3` after 12 cycles plus the IDLE cycle.
- Walk every row of the decode table with one instruction each. In EXEC/WB, `alu_op`, `selec_mux`, `selec_mux2` and `en_rf` match the row. `en` is high only in WB.
- Feed 0x00000000 then 0xFC000000:
  - NOP: `en=1`, `en_rf=0`.
  - HALT: `halted=1`, `busy=0`. No further `en` pulses over 20 cycles.
- Feed 0x8C010000 (lw, unsupported): `illegal=1` after DECODE, `en` is never asserted, and the FSM stays in STOP.
- Drop `run` during EXEC of an addi. WB still pulses `en`/`en_rf`, then the FSM holds in IDLE. Re-raising `run` resumes at FETCH.
- Pulse `rst` low during EXEC. Outputs take their reset values asynchronously, `rst_rf=1` for the INIT cycle, and `retired=0`.
